// File: rtl/irrigacao_zonas.sv
// irrigacao_zonas: multi-zone irrigation controller, top-level block of the irrigation board.
//   Every sensor goes through a 2-FF synchroniser and a debounce counter. The debounced values
//   feed a tank fill-valve FSM with fill timeout and sticky fault, one drip/sprinkler FSM per zone
//   with a minimum run time and a concurrency limit, and one 7-segment display.
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   UmidadeSolo[Z]      per-zone soil humidity, 1 = wet (0 = zone wants water)
//   UmidadeAr           air humidity, 1 = humid
//   Temperatura         1 = hot
//   High/Medium/Low     tank level sensors, code {High,Medium,Low}
//   ChaveSeletora       display select, 0 = tank level, 1 = zone scan
//   Gotejamento[Z]      drip valves
//   Aspersao[Z]         sprinkler valves
//   ValvulaEntrada      tank fill valve
//   Erro                sticky fault (invalid level code or fill timeout)
//   Alarme              Erro or tank below Low
//   Segmentos           {g,f,e,d,c,b,a}, active high
//   ZonaDisplay         zone shown in scan mode, 0 in tank mode

// One zone: idle / drip / sprinkler with a minimum-run timer.
module irrigacao_zona #(
  parameter int TEMPO_MIN = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,      // grant from the top-level arbiter
  input  logic modo_asp,   // 1 = sprinkler, sampled only at start
  input  logic forca_off,  // alarm: abort the run regardless of the timer
  input  logic molhado,    // debounced soil sensor, 1 = wet
  output logic ativa,
  output logic gotej,
  output logic asperg,
  output logic gotej_nxt,
  output logic asperg_nxt
);
  typedef enum logic [1:0] {OCIOSA, GOTEJANDO, ASPERGINDO} zona_t;
  localparam int TW = $clog2(TEMPO_MIN + 1);

  zona_t          estado, estado_nxt;
  logic [TW-1:0]  timer, timer_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= OCIOSA;
      timer  <= '0;
    end else begin
      estado <= estado_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    estado_nxt = estado;
    timer_nxt  = timer;
    case (estado)
      OCIOSA: begin
        if (start) begin
          estado_nxt = modo_asp ? ASPERGINDO : GOTEJANDO;
          timer_nxt  = TW'(TEMPO_MIN);
        end
      end
      GOTEJANDO, ASPERGINDO: begin
        if (forca_off) begin
          estado_nxt = OCIOSA;
          timer_nxt  = '0;
        end else if (timer == '0 && molhado) begin
          estado_nxt = OCIOSA;
        end else if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        estado_nxt = OCIOSA;
        timer_nxt  = '0;
      end
    endcase
  end

  assign ativa      = (estado != OCIOSA);
  assign gotej      = (estado == GOTEJANDO);
  assign asperg     = (estado == ASPERGINDO);
  assign gotej_nxt  = (estado_nxt == GOTEJANDO);
  assign asperg_nxt = (estado_nxt == ASPERGINDO);
endmodule

module irrigacao_zonas #(
  parameter int ZONAS       = 4,
  parameter int MAX_ATIVAS  = 2,
  parameter int DEBOUNCE    = 16,
  parameter int TEMPO_MIN   = 1000,
  parameter int TIMEOUT_ENC = 50000,
  parameter int DIV_DISPLAY = 5000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [ZONAS-1:0] UmidadeSolo,
  input  logic             UmidadeAr,
  input  logic             Temperatura,
  input  logic             High,
  input  logic             Medium,
  input  logic             Low,
  input  logic             ChaveSeletora,
  output logic [ZONAS-1:0] Gotejamento,
  output logic [ZONAS-1:0] Aspersao,
  output logic             ValvulaEntrada,
  output logic             Erro,
  output logic             Alarme,
  output logic [6:0]       Segmentos,
  output logic [2:0]       ZonaDisplay
);
  // Input bundle layout: {ChaveSeletora, Low, Medium, High, Temperatura, UmidadeAr, UmidadeSolo}
  localparam int NIN     = ZONAS + 6;
  localparam int I_AR    = ZONAS;
  localparam int I_TEMP  = ZONAS + 1;
  localparam int I_HIGH  = ZONAS + 2;
  localparam int I_MED   = ZONAS + 3;
  localparam int I_LOW   = ZONAS + 4;
  localparam int I_CHAVE = ZONAS + 5;
  // Sensors come out of reset reading "full tank, wet soil, humid, hot" so nothing
  // starts or alarms before real readings have been debounced. The switch starts in tank mode.
  localparam logic [NIN-1:0] RST_VAL = {1'b0, 5'b11111, {ZONAS{1'b1}}};

  localparam int DW  = $clog2(DEBOUNCE + 1);
  localparam int TW  = $clog2(TIMEOUT_ENC + 1);
  localparam int DVW = $clog2(DIV_DISPLAY + 1);

  localparam logic [6:0] SEG_E    = 7'b1111001;
  localparam logic [6:0] SEG_H    = 7'b1110110;
  localparam logic [6:0] SEG_N    = 7'b1010100;
  localparam logic [6:0] SEG_L    = 7'b0111000;
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] SEG_G    = 7'b0111101;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {ESPERA, ENCHENDO, FALHA} tanque_t;

  // ---------------- synchroniser + debounce ----------------
  logic [NIN-1:0]         bruto, sinc1, sinc2, deb;
  logic [NIN-1:0][DW-1:0] cnt;

  assign bruto = {ChaveSeletora, Low, Medium, High, Temperatura, UmidadeAr, UmidadeSolo};

  // deb only follows sinc2 after DEBOUNCE consecutive cycles of disagreement;
  // any cycle of agreement restarts the count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sinc1 <= RST_VAL;
      sinc2 <= RST_VAL;
      deb   <= RST_VAL;
      cnt   <= '0;
    end else begin
      sinc1 <= bruto;
      sinc2 <= sinc1;
      for (int b = 0; b < NIN; b++) begin
        if (sinc2[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == DW'(DEBOUNCE - 1)) begin
          deb[b] <= sinc2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  logic [ZONAS-1:0] solo;
  logic             ar, temp, alto, medio, baixo, chave;
  logic [2:0]       nivel;
  logic             nivel_ok;

  assign solo  = deb[ZONAS-1:0];
  assign ar    = deb[I_AR];
  assign temp  = deb[I_TEMP];
  assign alto  = deb[I_HIGH];
  assign medio = deb[I_MED];
  assign baixo = deb[I_LOW];
  assign chave = deb[I_CHAVE];
  assign nivel = {alto, medio, baixo};

  always_comb begin
    case (nivel)
      3'b000, 3'b001, 3'b011, 3'b111: nivel_ok = 1'b1;
      default:                        nivel_ok = 1'b0;
    endcase
  end

  // ---------------- tank FSM ----------------
  tanque_t       tanque, tanque_nxt;
  logic [TW-1:0] t_enc, t_enc_nxt;
  logic          falha_nxt, alarme_nxt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tanque <= ESPERA;
      t_enc  <= '0;
    end else begin
      tanque <= tanque_nxt;
      t_enc  <= t_enc_nxt;
    end
  end

  // ENCHENDO lasts at most TIMEOUT_ENC cycles; reaching High wins over the timeout
  // because it is tested first.
  always_comb begin
    tanque_nxt = tanque;
    t_enc_nxt  = t_enc;
    case (tanque)
      ESPERA: begin
        if (!nivel_ok) begin
          tanque_nxt = FALHA;
        end else if (!medio) begin
          tanque_nxt = ENCHENDO;
          t_enc_nxt  = '0;
        end
      end
      ENCHENDO: begin
        if (!nivel_ok)                          tanque_nxt = FALHA;
        else if (alto)                          tanque_nxt = ESPERA;
        else if (t_enc == TW'(TIMEOUT_ENC - 1)) tanque_nxt = FALHA;
        else                                    t_enc_nxt  = t_enc + 1'b1;
      end
      FALHA:   tanque_nxt = FALHA;
      default: tanque_nxt = FALHA;
    endcase
  end

  // Alarm is evaluated on the same debounced sample as the tank FSM so the zones
  // shut off on the same edge that Erro/Alarme rise.
  assign falha_nxt  = (tanque_nxt == FALHA);
  assign alarme_nxt = falha_nxt | ~baixo;

  assign ValvulaEntrada = (tanque == ENCHENDO);
  assign Erro           = (tanque == FALHA);

  always_ff @(posedge Clock) begin
    if (Reset) Alarme <= 1'b0;
    else       Alarme <= alarme_nxt;
  end

  // ---------------- zone arbitration + zone FSMs ----------------
  logic [ZONAS-1:0] ativa, inicio, gotej_nxt, asperg_nxt;
  logic [3:0]       ativos;
  logic             concedido;
  logic             modo_asp;

  assign modo_asp = ~ar | (medio & ~temp);

  // At most one grant per cycle, lowest index first. The count uses the current
  // states, so a zone finishing this cycle frees its slot only on the next one.
  always_comb begin
    ativos    = '0;
    inicio    = '0;
    concedido = 1'b0;
    for (int z = 0; z < ZONAS; z++) ativos = ativos + 4'(ativa[z]);
    for (int z = 0; z < ZONAS; z++) begin
      if (!concedido && !ativa[z] && !solo[z] && !alarme_nxt &&
          ativos < 4'(MAX_ATIVAS)) begin
        inicio[z] = 1'b1;
        concedido = 1'b1;
      end
    end
  end

  for (genvar z = 0; z < ZONAS; z++) begin : g_zona
    irrigacao_zona #(.TEMPO_MIN(TEMPO_MIN)) u_zona (
      .clk        (Clock),
      .rst        (Reset),
      .start      (inicio[z]),
      .modo_asp   (modo_asp),
      .forca_off  (alarme_nxt),
      .molhado    (solo[z]),
      .ativa      (ativa[z]),
      .gotej      (Gotejamento[z]),
      .asperg     (Aspersao[z]),
      .gotej_nxt  (gotej_nxt[z]),
      .asperg_nxt (asperg_nxt[z])
    );
  end

  // ---------------- display ----------------
  logic [DVW-1:0] div, div_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [7:0]     gotej_pad, asperg_pad;
  logic [6:0]     seg_nxt;

  assign gotej_pad  = 8'(gotej_nxt);
  assign asperg_pad = 8'(asperg_nxt);

  // Leaving scan mode parks the scan at zone 0, so every entry into scan mode restarts there.
  always_comb begin
    div_nxt = div;
    idx_nxt = idx;
    if (!chave) begin
      div_nxt = '0;
      idx_nxt = '0;
    end else if (div == DVW'(DIV_DISPLAY - 1)) begin
      div_nxt = '0;
      idx_nxt = (idx == 3'(ZONAS - 1)) ? 3'd0 : idx + 3'd1;
    end else begin
      div_nxt = div + 1'b1;
    end
  end

  // Display is built from next-state values so it changes on the same edge as the valves.
  always_comb begin
    seg_nxt = SEG_E;
    if (chave) begin
      if (gotej_pad[idx_nxt])       seg_nxt = SEG_G;
      else if (asperg_pad[idx_nxt]) seg_nxt = SEG_A;
      else                          seg_nxt = SEG_DASH;
    end else if (!falha_nxt) begin
      case (nivel)
        3'b111:  seg_nxt = SEG_H;
        3'b011:  seg_nxt = SEG_N;
        3'b001:  seg_nxt = SEG_L;
        3'b000:  seg_nxt = SEG_ZERO;
        default: seg_nxt = SEG_E;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div         <= '0;
      idx         <= '0;
      Segmentos   <= '0;
      ZonaDisplay <= '0;
    end else begin
      div         <= div_nxt;
      idx         <= idx_nxt;
      Segmentos   <= seg_nxt;
      ZonaDisplay <= chave ? idx_nxt : 3'd0;
    end
  end
endmodule
